mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch (IF) and the load/store unit (LSU, OP_LW/OP_SW traffic).
- Sits between the fetch/LSU stages and the unified memory interface.
- Single outstanding transaction. Fixed LSU priority, with an anti-starvation streak limit that forces fetch service.
- Routes each response back to the requester that owns the transaction; drops fetch responses killed by a flush (trap or branch redirect).

Parameters:
- MAX_LSU_STREAK, 4: maximum consecutive LSU grants while IF is also requesting before IF is forced through. Legal range 1..15.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  synchronous active-low reset
- if_req_i  in  1  fetch request
- if_addr_i  in  32  fetch address
- if_flush_i  in  1  discard any outstanding fetch response
- if_gnt_o  out  1  fetch request accepted
- if_rvalid_o  out  1  fetch response valid
- if_rdata_o  out  32  fetch instruction
- lsu_req_i  in  1  LSU request
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_addr_i  in  32  LSU address
- lsu_wdata_i  in  32  store data
- lsu_be_i  in  4  byte enables
- lsu_gnt_o  out  1  LSU request accepted
- lsu_rvalid_o  out  1  LSU response valid (load data or store acknowledge)
- lsu_rdata_o  out  32  load data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  write enable
- mem_addr_o  out  32  address
- mem_wdata_o  out  32  write data
- mem_be_o  out  4  byte enables; 4'hF for fetch
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  32  memory read data

Behaviour:
- Clocking: one clock, clk_i. Reset is synchronous and active-low on rstn_i.
- Reset:
  - state = IDLE, streak = 0, drop = 0.
  - All outputs are 0 while rstn_i = 0.
  - mem_rvalid_i arriving after reset (stale response) is ignored.
- States:
  - IDLE: no transaction outstanding.
  - WAIT_IF: fetch transaction outstanding.
  - WAIT_LSU: LSU transaction outstanding.
- Issue window: the port is free when state = IDLE, or when state = WAIT_x and mem_rvalid_i = 1 that cycle (back-to-back issue allowed).
- Selection while free (combinational, 0-cycle):
  - Only one requester active: that requester wins.
  - Both active: LSU wins unless streak == MAX_LSU_STREAK, in which case IF wins.
  - Winner's fields drive mem_* and mem_req_o = 1.
- Idle outputs: when no request is issued, mem_req_o = 0 and mem_addr_o, mem_wdata_o, mem_be_o, mem_we_o are driven 0.
- Fetch drive: mem_we_o = 0, mem_be_o = 4'hF, mem_wdata_o = 0.
- Grant:
  - x_gnt_o = mem_gnt_i & mem_req_o & (winner == x).
  - On grant, the next state is WAIT_x.
  - Requesters hold their request and fields stable until granted.
- Streak counter (4 bits, saturating at MAX_LSU_STREAK):
  - LSU granted while if_req_i = 1: streak + 1.
  - IF granted, or LSU granted with if_req_i = 0: streak = 0.
- Response:
  - In WAIT_x, mem_rvalid_i is forwarded to x_rvalid_o and mem_rdata_i to x_rdata_o in the same cycle.
  - If no new grant occurs that cycle, the next state is IDLE.
  - mem_rvalid_i in IDLE is ignored.
  - mem_rvalid_i never arrives in the same cycle as its own grant (memory contract); a response is at least 1 cycle after grant.
  - rdata outputs are 0 whenever the matching rvalid output is 0.
- Flush:
  - if_flush_i = 1 in WAIT_IF sets drop = 1.
  - While drop = 1, or in the cycle flush and the response coincide, the fetch response is consumed but if_rvalid_o stays 0.
  - drop clears when the response is consumed.
  - if_flush_i in any other state has no effect.
  - if_flush_i never masks if_req_i; a new fetch may be granted in the same cycle as the flush.
- Reset mid-transaction: returns to IDLE; the in-flight response is ignored.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: streak logic is removed. On contention, the requester not granted most recently wins. The last-winner flag resets to IF, so LSU wins the first contention after reset.
- Undefined: LSU priority with the MAX_LSU_STREAK limit, as in Behaviour.

Test Plan:
1. Reset: rstn_i = 0 for 3 cycles with if_req_i = lsu_req_i = 1 -> all outputs 0. Then release with mem_gnt_i = 1 -> LSU granted in the first cycle.
2. Contention, MAX_LSU_STREAK = 4: both requesting continuously, 1-cycle memory latency -> grant order LSU, LSU, LSU, LSU, IF, LSU...
3. Back-to-back: LSU load to 0x100 outstanding, IF requesting. mem_rvalid_i = 1 with rdata 0xDEADBEEF, mem_gnt_i = 1 in the same cycle -> lsu_rvalid_o = 1 with lsu_rdata_o = 0xDEADBEEF; IF granted that cycle with mem_addr_o = if_addr_i and mem_be_o = 4'hF.
4. Flush: fetch to 0x40 granted, if_flush_i pulsed 1 cycle, response arrives 3 cycles later -> if_rvalid_o stays 0, state returns to IDLE.
5. Store: lsu_we_i = 1, addr 0x200, wdata 0x12345678, be 4'b0011 -> mem_* mirror these values; on ack, lsu_rvalid_o = 1 and if_rvalid_o = 0.
6. MEM_ARB_ROUND_ROBIN_EN defined, both requesting continuously -> grants strictly alternate LSU, IF, LSU, IF.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch (IF) and
//               the load/store unit (LSU). Only one transaction is
//               outstanding at a time. LSU has fixed priority, but after
//               MAX_LSU_STREAK consecutive contended LSU grants, IF is forced
//               through. Each response is routed to the requester that owns
//               the transaction. A fetch response killed by a flush is
//               consumed silently.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option: MEM_ARB_ROUND_ROBIN_EN
//               When defined, the streak limit is replaced by round-robin
//               arbitration on contention. The last-winner flag resets to IF,
//               so the LSU wins the first contention after reset.
// ----------------------------------------------------------------------------
// Ports:
//   clk_i, rstn_i                : clock, synchronous active-low reset
//   if_req_i / if_addr_i         : fetch request and address
//   if_flush_i                   : discard the outstanding fetch response
//   if_gnt_o / if_rvalid_o / if_rdata_o    : fetch grant and response
//   lsu_req_i / lsu_we_i / lsu_addr_i / lsu_wdata_i / lsu_be_i : LSU request
//   lsu_gnt_o / lsu_rvalid_o / lsu_rdata_o : LSU grant and response
//   mem_req_o / mem_we_o / mem_addr_o / mem_wdata_o / mem_be_o : memory request
//   mem_gnt_i / mem_rvalid_i / mem_rdata_i : memory grant and response
// ============================================================================
module mem_port_arbiter #(
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  // instruction fetch side
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  // load/store side
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [3:0]  lsu_be_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  // unified memory side
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_IF  = 2'd1,
    ST_WAIT_LSU = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_drop;
  logic   w_drop_nxt;

  logic   w_free;
  logic   w_lsu_wins_tie;
  logic   w_pick_lsu;
  logic   w_pick_if;
  logic   w_issue;
  logic   w_rsp_if;
  logic   w_rsp_lsu;

  // --------------------------------------------------------------------------
  // Contention policy
  // --------------------------------------------------------------------------
`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = LSU was granted most recently; resets to IF so LSU wins first tie.
  logic r_last_lsu;

  assign w_lsu_wins_tie = ~r_last_lsu;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_last_lsu <= 1'b0;
    end else if (lsu_gnt_o) begin
      r_last_lsu <= 1'b1;
    end else if (if_gnt_o) begin
      r_last_lsu <= 1'b0;
    end
  end
`else
  localparam logic [3:0] C_STREAK_MAX = 4'(MAX_LSU_STREAK);

  // Consecutive LSU grants won while IF was also waiting.
  logic [3:0] r_streak;

  assign w_lsu_wins_tie = (r_streak != C_STREAK_MAX);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_streak <= 4'd0;
    end else if (lsu_gnt_o) begin
      if (if_req_i) begin
        r_streak <= (r_streak == C_STREAK_MAX) ? C_STREAK_MAX : r_streak + 4'd1;
      end else begin
        r_streak <= 4'd0;
      end
    end else if (if_gnt_o) begin
      r_streak <= 4'd0;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Selection and memory request drive
  // --------------------------------------------------------------------------
  // The port frees up in the same cycle the outstanding response returns,
  // which lets a new request issue back-to-back.
  assign w_free     = (r_state == ST_IDLE) || mem_rvalid_i;
  assign w_pick_lsu = lsu_req_i & (~if_req_i | w_lsu_wins_tie);
  assign w_pick_if  = if_req_i & ~w_pick_lsu;
  // Gating by rstn_i keeps every output at 0 while reset is held, even
  // before the first clock edge has cleared the state register.
  assign w_issue    = rstn_i & w_free & (if_req_i | lsu_req_i);

  always_comb begin
    mem_req_o   = w_issue;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = 32'd0;
    mem_be_o    = 4'd0;
    if (w_issue && w_pick_lsu) begin
      mem_we_o    = lsu_we_i;
      mem_addr_o  = lsu_addr_i;
      mem_wdata_o = lsu_wdata_i;
      mem_be_o    = lsu_be_i;
    end else if (w_issue && w_pick_if) begin
      mem_addr_o  = if_addr_i;
      mem_be_o    = 4'hF;
    end
  end

  assign lsu_gnt_o = mem_gnt_i & w_issue & w_pick_lsu;
  assign if_gnt_o  = mem_gnt_i & w_issue & w_pick_if;

  // --------------------------------------------------------------------------
  // Response routing
  // --------------------------------------------------------------------------
  assign w_rsp_if  = rstn_i & (r_state == ST_WAIT_IF)  & mem_rvalid_i;
  assign w_rsp_lsu = rstn_i & (r_state == ST_WAIT_LSU) & mem_rvalid_i;

  // A flush arriving together with the response kills it too.
  assign if_rvalid_o  = w_rsp_if & ~r_drop & ~if_flush_i;
  assign if_rdata_o   = if_rvalid_o ? mem_rdata_i : 32'd0;
  assign lsu_rvalid_o = w_rsp_lsu;
  assign lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : 32'd0;

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;

    if ((r_state != ST_IDLE) && mem_rvalid_i) begin
      w_state_nxt = ST_IDLE;
    end
    if (lsu_gnt_o) begin
      w_state_nxt = ST_WAIT_LSU;
    end else if (if_gnt_o) begin
      w_state_nxt = ST_WAIT_IF;
    end

    // The drop flag belongs to the outstanding fetch only; it is cleared
    // when that response is consumed, even if a new fetch issues alongside.
    if (r_state == ST_WAIT_IF) begin
      if (mem_rvalid_i) begin
        w_drop_nxt = 1'b0;
      end else if (if_flush_i) begin
        w_drop_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter. Expected
//               values are hand-computed per vector. The contention sequence
//               follows MEM_ARB_ROUND_ROBIN_EN when that macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk_i;
  logic        rstn_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic [3:0]  lsu_be_i;
  logic        lsu_gnt_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.MAX_LSU_STREAK(4)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_flush_i   (if_flush_i),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .lsu_req_i    (lsu_req_i),
    .lsu_we_i     (lsu_we_i),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_wdata_i  (lsu_wdata_i),
    .lsu_be_i     (lsu_be_i),
    .lsu_gnt_o    (lsu_gnt_o),
    .lsu_rvalid_o (lsu_rvalid_o),
    .lsu_rdata_o  (lsu_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge; inputs change there.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  logic [6:0] exp_lsu;

  initial begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_lsu = 7'b1010101;   // L I L I L I L
`else
    exp_lsu = 7'b1101111;   // L L L L I L L
`endif
    // ---------------- reset with both requesting ----------------
    rstn_i       = 1'b0;
    if_req_i     = 1'b1;
    if_addr_i    = 32'h0000_1000;
    if_flush_i   = 1'b0;
    lsu_req_i    = 1'b1;
    lsu_we_i     = 1'b0;
    lsu_addr_i   = 32'h0000_2000;
    lsu_wdata_i  = 32'd0;
    lsu_be_i     = 4'hF;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
      check_eq("rst_gnts", {30'd0, if_gnt_o, lsu_gnt_o}, 32'd0);
      check_eq("rst_rvalids", {30'd0, if_rvalid_o, lsu_rvalid_o}, 32'd0);
      check_eq("rst_addr", mem_addr_o, 32'd0);
      check_eq("rst_rdata", if_rdata_o | lsu_rdata_o, 32'd0);
      step();
    end

    // ---------------- contention, 1-cycle latency ----------------
    rstn_i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      mem_rvalid_i = (k > 0);
      mem_rdata_i  = 32'h100 + k;
      #1;
      check_eq("cont_lsu_gnt", {31'd0, lsu_gnt_o}, {31'd0, exp_lsu[k]});
      check_eq("cont_if_gnt", {31'd0, if_gnt_o}, {31'd0, ~exp_lsu[k]});
      check_eq("cont_addr", mem_addr_o, exp_lsu[k] ? 32'h0000_2000 : 32'h0000_1000);
      if (k > 0) begin
        check_eq("cont_lsu_rvalid", {31'd0, lsu_rvalid_o}, {31'd0, exp_lsu[k-1]});
        check_eq("cont_if_rvalid", {31'd0, if_rvalid_o}, {31'd0, ~exp_lsu[k-1]});
      end
      step();
    end
    // drain the last (LSU) transaction
    if_req_i = 1'b0; lsu_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'h0000_0106;
    #1;
    check_eq("drain_lsu_rvalid", {31'd0, lsu_rvalid_o}, 32'd1);
    check_eq("drain_lsu_rdata", lsu_rdata_o, 32'h0000_0106);
    check_eq("drain_mem_req", {31'd0, mem_req_o}, 32'd0);
    check_eq("drain_idle_fields", mem_addr_o | mem_wdata_o | {28'd0, mem_be_o}, 32'd0);
    step();

    // ---------------- back-to-back LSU -> IF ----------------
    mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h0000_0100; lsu_be_i = 4'hF;
    #1;
    check_eq("ld_gnt", {31'd0, lsu_gnt_o}, 32'd1);
    check_eq("ld_addr", mem_addr_o, 32'h0000_0100);
    check_eq("ld_we", {31'd0, mem_we_o}, 32'd0);
    step();
    lsu_req_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h0000_0080; mem_gnt_i = 1'b0;
    #1;
    check_eq("busy_no_req", {31'd0, mem_req_o}, 32'd0);
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; mem_gnt_i = 1'b1;
    #1;
    check_eq("b2b_lsu_rvalid", {31'd0, lsu_rvalid_o}, 32'd1);
    check_eq("b2b_lsu_rdata", lsu_rdata_o, 32'hDEAD_BEEF);
    check_eq("b2b_if_rvalid", {31'd0, if_rvalid_o}, 32'd0);
    check_eq("b2b_if_rdata", if_rdata_o, 32'd0);
    check_eq("b2b_if_gnt", {31'd0, if_gnt_o}, 32'd1);
    check_eq("b2b_addr", mem_addr_o, 32'h0000_0080);
    check_eq("b2b_be", {28'd0, mem_be_o}, 32'h0000_000F);
    check_eq("b2b_we", {31'd0, mem_we_o}, 32'd0);
    step();

    // ---------------- fetch response, then flushed fetch ----------------
    mem_rdata_i = 32'h0000_0013; if_addr_i = 32'h0000_0040;
    #1;
    check_eq("fetch_rvalid", {31'd0, if_rvalid_o}, 32'd1);
    check_eq("fetch_rdata", if_rdata_o, 32'h0000_0013);
    check_eq("fetch40_gnt", {31'd0, if_gnt_o}, 32'd1);
    check_eq("fetch40_addr", mem_addr_o, 32'h0000_0040);
    step();
    if_req_i = 1'b0; if_flush_i = 1'b1; mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;
    #1;
    check_eq("flush_if_rvalid", {31'd0, if_rvalid_o}, 32'd0);
    step();
    if_flush_i = 1'b0;
    step();
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA_5555;
    #1;
    check_eq("dropped_rvalid", {31'd0, if_rvalid_o}, 32'd0);
    check_eq("dropped_rdata", if_rdata_o, 32'd0);
    check_eq("dropped_lsu_rvalid", {31'd0, lsu_rvalid_o}, 32'd0);
    step();

    // ---------------- store (also proves return to IDLE) ----------------
    mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0;
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h0000_0200;
    lsu_wdata_i = 32'h1234_5678; lsu_be_i = 4'b0011;
    #1;
    check_eq("st_req_after_drop", {31'd0, mem_req_o}, 32'd1);
    check_eq("st_we", {31'd0, mem_we_o}, 32'd1);
    check_eq("st_addr", mem_addr_o, 32'h0000_0200);
    check_eq("st_wdata", mem_wdata_o, 32'h1234_5678);
    check_eq("st_be", {28'd0, mem_be_o}, 32'h0000_0003);
    check_eq("st_no_gnt", {31'd0, lsu_gnt_o}, 32'd0);
    step();
    mem_gnt_i = 1'b1;
    #1;
    check_eq("st_gnt", {31'd0, lsu_gnt_o}, 32'd1);
    step();
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'd0;
    #1;
    check_eq("st_ack_lsu", {31'd0, lsu_rvalid_o}, 32'd1);
    check_eq("st_ack_if", {31'd0, if_rvalid_o}, 32'd0);
    step();
    mem_rdata_i = 32'h5A5A_5A5A;
    #1;
    check_eq("idle_stale_rvalid", {30'd0, if_rvalid_o, lsu_rvalid_o}, 32'd0);
    check_eq("idle_stale_rdata", lsu_rdata_o | if_rdata_o, 32'd0);
    step();

    // ---------------- flush coinciding with response ----------------
    mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h0000_0044;
    #1;
    check_eq("co_if_gnt", {31'd0, if_gnt_o}, 32'd1);
    step();
    if_req_i = 1'b0; if_flush_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h99;
    mem_gnt_i = 1'b0;
    #1;
    check_eq("co_flush_rvalid", {31'd0, if_rvalid_o}, 32'd0);
    step();
    if_flush_i = 1'b0; mem_rvalid_i = 1'b0;

    // ---------------- reset mid-transaction ----------------
    lsu_req_i = 1'b1; lsu_addr_i = 32'h0000_0300; lsu_be_i = 4'hF; mem_gnt_i = 1'b1;
    #1;
    check_eq("mid_lsu_gnt", {31'd0, lsu_gnt_o}, 32'd1);
    step();
    rstn_i = 1'b0; lsu_req_i = 1'b0; mem_gnt_i = 1'b0;
    #1;
    check_eq("mid_rst_req", {31'd0, mem_req_o}, 32'd0);
    step();
    rstn_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
    #1;
    check_eq("mid_rst_stale", {31'd0, lsu_rvalid_o}, 32'd0);
    step();

    // ---------------- fresh fetch after the flushes ----------------
    mem_rvalid_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h0000_0048; mem_gnt_i = 1'b1;
    #1;
    check_eq("fresh_if_gnt", {31'd0, if_gnt_o}, 32'd1);
    step();
    if_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77;
    #1;
    check_eq("fresh_if_rvalid", {31'd0, if_rvalid_o}, 32'd1);
    check_eq("fresh_if_rdata", if_rdata_o, 32'h77);
    step();
    mem_rvalid_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
